// File: rtl/a2d_spi_intf_if.sv
// a2d_spi_intf_if: request/response and SPI pin bundle for the A2D responder.
//   start_conv, chnnl    : conversion request from the motion controller
//   cnv_cmplt, A2D_res   : completion level and 12-bit result
//   SS_n, SCLK, MOSI     : SPI outputs toward the ADC
//   MISO                 : SPI input from the ADC
// The slave modport is the responder's view; master is the requester/ADC side.
interface a2d_spi_intf_if;
  logic        start_conv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] A2D_res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport slave (
    input  start_conv, chnnl, MISO,
    output cnv_cmplt, A2D_res, SS_n, SCLK, MOSI
  );

  modport master (
    output start_conv, chnnl, MISO,
    input  cnv_cmplt, A2D_res, SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/a2d_spi_intf.sv
// a2d_spi_intf: responder-side A2D interface. Each accepted request runs two
// 16-bit SPI frames to an 8-channel 12-bit ADC: frame 1 shifts out the channel
// command, frame 2 shifts in the result. The frames are separated by one SCLK
// period with SS_n high.
//   clk, rst   : system clock, synchronous active-high reset
//   bus.slave  : start_conv/chnnl in, cnv_cmplt/A2D_res out,
//                SS_n/SCLK/MOSI out, MISO in
// Parameter SCLK_DIV: clk cycles per SCLK period (even, >= 4).
module a2d_spi_intf #(
  parameter int SCLK_DIV = 32
) (
  input  logic           clk,
  input  logic           rst,
  a2d_spi_intf_if.slave  bus
);

  localparam int DIV_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_C   = DIV_W'(SCLK_DIV / 2);
  localparam logic [4:0]       PER_LAST = 5'd16;

  typedef enum logic [2:0] {IDLE, FRM1, GAP, FRM2, DONE} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;     // cycle within the current SCLK period
  logic [4:0]       per_q, per_d;     // SCLK period index in a frame, 0..16
  logic [15:0]      shreg_q, shreg_d;
  logic             ss_n_q, ss_n_d;
  logic             sclk_q, sclk_d;
  logic             cmplt_q, cmplt_d;
  logic [11:0]      res_q, res_d;

  logic div_end;
  logic frame_end;
  logic in_frame;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    per_d   = per_q;
    shreg_d = shreg_q;
    cmplt_d = cmplt_q;
    res_d   = res_q;

    div_end   = (div_q == DIV_LAST);
    // A frame is 17 periods: 16 clocked bits plus a trailing high period.
    frame_end = div_end && (per_q == PER_LAST);

    case (state_q)
      IDLE, DONE: begin
        if (bus.start_conv) begin
          state_d = FRM1;
          div_d   = '0;
          per_d   = '0;
          shreg_d = {2'b00, bus.chnnl, 11'h000};
          cmplt_d = 1'b0;
        end
      end
      FRM1, FRM2: begin
        // The first cycle of each period after period 0 is an SCLK-high
        // (rising-edge) cycle: sample MISO there, MSB first.
        if (div_q == '0 && per_q != '0) begin
          shreg_d = {shreg_q[14:0], bus.MISO};
        end
        if (div_end) begin
          div_d = '0;
          if (per_q != PER_LAST) per_d = per_q + 5'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
        if (frame_end) begin
          div_d = '0;
          per_d = '0;
          if (state_q == FRM1) begin
            state_d = GAP;
            shreg_d = 16'h0000;
          end else begin
            state_d = DONE;
            res_d   = shreg_q[11:0];
            cmplt_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (div_end) begin
          state_d = FRM2;
          div_d   = '0;
          per_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin levels are derived from the next state/counters so the SPI outputs
    // come straight from flops.
    in_frame = (state_d == FRM1) || (state_d == FRM2);
    ss_n_d   = !in_frame;
    sclk_d   = !(in_frame && (per_d < PER_LAST) && (div_d >= HALF_C));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      per_q   <= '0;
      shreg_q <= 16'h0000;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      cmplt_q <= 1'b0;
      res_q   <= 12'h000;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      per_q   <= per_d;
      shreg_q <= shreg_d;
      ss_n_q  <= ss_n_d;
      sclk_q  <= sclk_d;
      cmplt_q <= cmplt_d;
      res_q   <= res_d;
    end
  end

  assign bus.SS_n      = ss_n_q;
  assign bus.SCLK      = sclk_q;
  assign bus.MOSI      = shreg_q[15];
  assign bus.cnv_cmplt = cmplt_q;
  assign bus.A2D_res   = res_q;

endmodule

// File: tb/tb_a2d_spi_intf.sv
module tb_a2d_spi_intf;

  logic clk;
  logic rst;

  a2d_spi_intf_if ba();
  a2d_spi_intf_if bb();

  a2d_spi_intf #(.SCLK_DIV(32)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
  a2d_spi_intf #(.SCLK_DIV(4))  dut_b (.clk(clk), .rst(rst), .bus(bb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- ADC model and bus monitor for instance A (D=32) ----------
  logic [15:0] adc_word = 16'h0000;
  logic        ssp = 1'b1, sclkp = 1'b1, first_fall = 1'b0;
  logic [15:0] msr = 16'h0000, mcap = 16'h0000;
  int          lowc = 0, highc = 0, rcnt = 0, fidx = 0;
  int          len_f[2], rises_f[2];
  logic [15:0] mosi_f[2];
  int          gap_len = 0, bad_sclk = 0, frame_starts = 0;
  logic [15:0] cmd_log[64];
  int          conv_n = 0;
  int          cm_run = 0, runs = 0, run_bad = 0;

  always @(negedge clk) begin
    if (rst) begin
      fidx = 0; ssp = 1'b1; sclkp = 1'b1; lowc = 0; ba.MISO = 1'b0;
    end else begin
      if (ba.SS_n && !ba.SCLK) bad_sclk++;
      if (!ba.SS_n) begin
        if (ssp) begin
          frame_starts++; gap_len = highc; lowc = 0; rcnt = 0; mcap = 16'h0000;
          msr = (fidx != 0) ? adc_word : 16'hA5A5; first_fall = 1'b1;
        end
        lowc++;
        if (ba.SCLK && !sclkp) begin rcnt++; mcap = {mcap[14:0], ba.MOSI}; end
        if (!ba.SCLK && sclkp) begin
          if (first_fall) first_fall = 1'b0;
          else msr = {msr[14:0], 1'b0};
        end
        ba.MISO = msr[15];
      end else begin
        if (!ssp) begin
          len_f[fidx] = lowc; rises_f[fidx] = rcnt; mosi_f[fidx] = mcap;
          if (fidx == 0) begin cmd_log[conv_n % 64] = mcap; conv_n++; end
          fidx = 1 - fidx; highc = 0;
        end
        highc++;
      end
      ssp = ba.SS_n; sclkp = ba.SCLK;
      if (ba.cnv_cmplt) cm_run++;
      else begin
        if (cm_run > 0) begin runs++; if (cm_run != 1) run_bad++; end
        cm_run = 0;
      end
    end
  end

  // ---------------- ADC model and frame length monitor for instance B (D=4) --
  logic        bssp = 1'b1, bsclkp = 1'b1, bff = 1'b0;
  logic [15:0] bmsr = 16'h0000;
  int          blowc = 0, bfidx = 0;
  int          blen[2];

  always @(negedge clk) begin
    if (rst) begin
      bfidx = 0; bssp = 1'b1; bsclkp = 1'b1; bb.MISO = 1'b0;
    end else begin
      if (!bb.SS_n) begin
        if (bssp) begin
          blowc = 0; bmsr = (bfidx != 0) ? 16'h0FFF : 16'h0000; bff = 1'b1;
        end
        blowc++;
        if (!bb.SCLK && bsclkp) begin
          if (bff) bff = 1'b0;
          else bmsr = {bmsr[14:0], 1'b0};
        end
        bb.MISO = bmsr[15];
      end else if (!bssp) begin
        blen[bfidx] = blowc; bfidx = 1 - bfidx;
      end
      bssp = bb.SS_n; bsclkp = bb.SCLK;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input logic [2:0] ch);
    ba.chnnl = ch;
    ba.start_conv = 1'b1;
    step(1);
    ba.start_conv = 1'b0;
  endtask

  task automatic wait_cmplt(input int limit, output int n);
    n = 0;
    while (!ba.cnv_cmplt && n < limit) begin
      step(1);
      n++;
    end
  endtask

  int n, base, r0, rb0, fs0, viol;

  initial begin
    rst = 1'b1;
    ba.start_conv = 1'b1; ba.chnnl = 3'd0;
    bb.start_conv = 1'b0; bb.chnnl = 3'd0;

    // Reset held with a pending request
    step(5);
    chk("rst_ss_n", ba.SS_n, 1);
    chk("rst_sclk", ba.SCLK, 1);
    chk("rst_cmplt", ba.cnv_cmplt, 0);
    chk("rst_res", ba.A2D_res, 0);
    rst = 1'b0; ba.start_conv = 1'b0;
    step(3);
    chk("rst_no_frames", frame_starts, 0);
    chk("rst_no_sclk_edges", bad_sclk, 0);
    chk("rst_idle_ss_n", ba.SS_n, 1);

    // Basic conversion, channel 5, ADC returns F1F4
    adc_word = 16'hF1F4;
    start_pulse(3'd5);
    wait_cmplt(1300, n);
    chk("basic_latency", n + 1, 1121);
    chk("basic_res", ba.A2D_res, 12'h1F4);
    chk("basic_cmplt", ba.cnv_cmplt, 1);
    step(2);
    chk("basic_cmd", mosi_f[0], 16'h2800);
    chk("basic_frm2_mosi", mosi_f[1], 16'h0000);
    chk("basic_rises_f1", rises_f[0], 16);
    chk("basic_rises_f2", rises_f[1], 16);
    chk("basic_len_f1", len_f[0], 544);
    chk("basic_len_f2", len_f[1], 544);
    chk("basic_gap", gap_len, 32);
    chk("basic_sclk_idle", bad_sclk, 0);

    // Completion holds while no request arrives
    adc_word = 16'h7ABC;
    start_pulse(3'd3);
    wait_cmplt(1300, n);
    chk("hold_res_start", ba.A2D_res, 12'hABC);
    step(2);
    fs0 = frame_starts; viol = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if (ba.cnv_cmplt !== 1'b1 || ba.A2D_res !== 12'hABC || ba.SS_n !== 1'b1) viol++;
    end
    chk("hold_violations", viol, 0);
    chk("hold_no_frames", frame_starts, fs0);

    // start_conv held high; channel changes mid-frame of the first conversion
    adc_word = 16'h0456;
    ba.chnnl = 3'd0;
    base = conv_n;
    ba.start_conv = 1'b1;
    step(100);
    chk("busy_cmplt_dropped", ba.cnv_cmplt, 0);
    r0 = runs; rb0 = run_bad;
    ba.chnnl = 3'd7;
    step(29900);
    ba.start_conv = 1'b0;
    wait_cmplt(1300, n);
    chk("busy_drain_timeout", n < 1300, 1);
    step(2);
    chk("busy_cmd_first", cmd_log[base % 64], 16'h0000);
    chk("busy_cmd_second", cmd_log[(base + 1) % 64], 16'h3800);
    chk("busy_cmd_last", cmd_log[(conv_n - 1) % 64], 16'h3800);
    chk("busy_conv_count", (conv_n - base) >= 26, 1);
    chk("busy_runs", (runs - r0) >= 20, 1);
    chk("busy_cmplt_one_cycle", run_bad - rb0, 0);
    chk("busy_res", ba.A2D_res, 12'h456);

    // Reset in the middle of frame 1
    adc_word = 16'h0123;
    start_pulse(3'd2);
    step(299);
    chk("mid_in_frame", ba.SS_n, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_ss_n", ba.SS_n, 1);
    chk("mid_sclk", ba.SCLK, 1);
    chk("mid_cmplt", ba.cnv_cmplt, 0);
    chk("mid_res", ba.A2D_res, 0);
    step(5);
    chk("mid_stays_idle", ba.SS_n, 1);
    start_pulse(3'd2);
    wait_cmplt(1300, n);
    chk("mid_latency", n + 1, 1121);
    chk("mid_res_new", ba.A2D_res, 12'h123);
    step(2);
    chk("mid_cmd", mosi_f[0], 16'h1000);
    chk("mid_len_f1", len_f[0], 544);

    // SCLK_DIV=4 instance
    bb.chnnl = 3'd1;
    bb.start_conv = 1'b1;
    step(1);
    bb.start_conv = 1'b0;
    n = 0;
    while (!bb.cnv_cmplt && n < 300) begin
      step(1);
      n++;
    end
    chk("d4_latency", n + 1, 141);
    chk("d4_res", bb.A2D_res, 12'hFFF);
    step(2);
    chk("d4_len_f1", blen[0], 68);
    chk("d4_len_f2", blen[1], 68);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
